udp_tx_framer: RTL and testbench
================================

// Module: udp_tx_framer
// PURPOSE
//  Builds one Ethernet/IPv4/UDP frame around a payload held in a show-ahead payload buffer.
//  Presents the frame on the 32-bit sop/eop/mod/wren MAC-side stream that the TX arbiter's UDP1 port consumes.
//  Sits directly upstream of the arbiter. Requests the channel with en_udp and streams once the forwarded tx_rdy arrives.
// PARAMETERS
//  SRC_MAC   48'h0200_0000_0001  source MAC
//  DST_MAC   48'hFFFF_FFFF_FFFF  destination MAC
//  SRC_IP    32'hC0A8_0001       source IPv4 address
//  DST_IP    32'hC0A8_0002       destination IPv4 address
//  SRC_PORT  16'd5000            UDP source port
//  DST_PORT  16'd5001            UDP destination port
//  MAX_LEN   1472                max payload bytes; longer frames are rejected
//  GAP       4                   idle cycles enforced after eop before the next request (min 4)
// PORTS
//  clk       in   1   clock
//  rst       in   1   asynchronous active-high reset
//  pl_valid  in   1   complete payload present in buffer; pl_len stable while high
//  pl_len    in   16  payload length, bytes
//  pl_data   in   32  show-ahead payload word, byte0 in [31:24]
//  pl_rd     out  1   consume current pl_data word
//  pl_done   out  1   1-cycle pulse: payload finished (sent or rejected)
//  en_udp    out  1   channel request to arbiter
//  tx_rdy    in   1   arbiter-forwarded MAC ready (0 unless granted)
//  tx_wren   out  1   word valid
//  tx_sop    out  1   first word of frame
//  tx_eop    out  1   last word of frame
//  tx_mod    out  2   empty bytes in last word (0 = all 4 valid); 0 on non-eop words
//  tx_data   out  32  frame word, big-endian
// BEHAVIOUR
//  - Reset: every output is 0. FSM goes to IDLE. IP ID counter is 0.
//  - FSM: IDLE -> CHECK -> REQ -> HDR -> PAY -> GAPW -> IDLE.
//  - IDLE: leave on pl_valid=1 (pl_len latched).
//  - CHECK: 1 cycle.
//    - pl_len==0 or pl_len>MAX_LEN: pulse pl_done, go to GAPW. No request and no pl_rd.
//    - Otherwise compute the IP header checksum (ones-complement sum of fixed fields plus total_len and id, folded and inverted), then go to REQ.
//  - REQ: en_udp=1. Move to HDR on the first cycle tx_rdy=1; en_udp drops in that same cycle's update.
//  - HDR: 11 words back to back, wren=1, sop on W0. The leading 2-byte pad is stripped by the MAC (shift16 mode).
//    - W0 {16'h0,DST_MAC[47:32]}   W1 DST_MAC[31:0]      W2 SRC_MAC[47:16]
//    - W3 {SRC_MAC[15:0],16'h0800} W4 {16'h4500,len+28}  W5 {ip_id,16'h4000}
//    - W6 {8'd64,8'd17,csum}       W7 SRC_IP             W8 DST_IP
//    - W9 {SRC_PORT,DST_PORT}      W10 {len+8,16'h0000}  (UDP checksum disabled)
//  - PAY: N=ceil(len/4) words, no gaps, pl_rd=1 each cycle, tx_data<=pl_data.
//    - Last word: eop=1, tx_mod=(4-len[1:0])&3, pl_done pulses. Unused bytes of the last word are 0.
//  - Frame is gapless from sop to eop: wren never drops mid-frame, because the arbiter ends the grant on a wren falling edge.
//  - tx_rdy is sampled only in REQ. Once started, the frame completes regardless of tx_rdy.
//  - GAPW: hold GAP cycles with all stream outputs 0, then go to IDLE.
//  - All stream outputs are registered: 1 cycle from the state decision to the port.
//  - Reset mid-frame: outputs go to 0 immediately. The partial payload is not drained; the buffer owner flushes it.
//  - pl_valid dropping after CHECK is ignored until IDLE.
// CONFIGURATION
//  UDP_IPID_INC_EN
//  - Defined: ip_id starts at 0 and increments mod 2^16 after each transmitted frame; rejected frames do not count. The checksum uses the current id.
//  - Undefined: ip_id is constant 16'h0000.
// TESTING
//  1. len=18, tx_rdy=1 at REQ -> 16 words; W4=32'h4500_002E, W10=32'h001A_0000; last word eop, mod=2; one pl_done.
//  2. len=1 -> 12 words; last word data[31:24]=byte0, low bytes 0, mod=3; 1 pl_rd.
//  3. len=1472 -> 379 contiguous wren cycles; W4 low half 16'h05DC; mod=0; 368 pl_rd.
//  4. tx_rdy held 0 for 20 cycles in REQ -> en_udp stays 1, no wren; sop 1 cycle after tx_rdy rises.
//  5. len=0 and len=1473 -> pl_done pulse, en_udp and wren never asserted; next valid frame still sent.
//  6. Checksum/ID: two frames with UDP_IPID_INC_EN -> ids 0,1; W6[15:0] matches reference-model checksum; rst mid-PAY -> outputs 0 next edge.

Source files
------------

// File: rtl/udp_tx_framer_if.sv
// Payload-buffer and MAC-side stream signals of the UDP TX framer.
//
// Handshakes:
//  - Payload side: pl_valid high means a complete payload sits in a show-ahead
//    buffer; pl_data always shows the current word and pl_rd=1 in a cycle
//    consumes it at that clock edge. pl_done pulses once per payload, whether
//    it was sent or rejected.
//  - Stream side: en_udp requests the channel; tx_rdy (only non-zero while
//    granted) is sampled during the request. Once started, tx_wren stays high
//    from sop to eop with no gaps; there is no back-pressure mid-frame.
interface udp_tx_framer_if;
    logic        pl_valid;
    logic [15:0] pl_len;
    logic [31:0] pl_data;
    logic        pl_rd;
    logic        pl_done;
    logic        en_udp;
    logic        tx_rdy;
    logic        tx_wren;
    logic        tx_sop;
    logic        tx_eop;
    logic [1:0]  tx_mod;
    logic [31:0] tx_data;

    // Framer side.
    modport master (
        input  pl_valid, pl_len, pl_data, tx_rdy,
        output pl_rd, pl_done, en_udp, tx_wren, tx_sop, tx_eop, tx_mod, tx_data
    );

    // Payload buffer / arbiter side.
    modport slave (
        output pl_valid, pl_len, pl_data, tx_rdy,
        input  pl_rd, pl_done, en_udp, tx_wren, tx_sop, tx_eop, tx_mod, tx_data
    );
endinterface

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: wraps one payload from a show-ahead buffer in an
// Ethernet/IPv4/UDP frame and streams it as 32-bit sop/eop/mod/wren words
// (leading 2-byte pad, stripped by the MAC in shift16 mode).
// Optional build macro: UDP_IPID_INC_EN -- when defined the IPv4 ID counts
// transmitted frames; otherwise the ID is constant zero.
module udp_tx_framer #(
    parameter logic [47:0] SRC_MAC  = 48'h0200_0000_0001,
    parameter logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF,
    parameter logic [31:0] SRC_IP   = 32'hC0A8_0001,
    parameter logic [31:0] DST_IP   = 32'hC0A8_0002,
    parameter logic [15:0] SRC_PORT = 16'd5000,
    parameter logic [15:0] DST_PORT = 16'd5001,
    parameter int          MAX_LEN  = 1472,
    parameter int          GAP      = 4
) (
    input  logic             clk,
    input  logic             rst,
    udp_tx_framer_if.master  bus,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_REQ   = 3'd2,
        S_HDR   = 3'd3,
        S_PAY   = 3'd4,
        S_GAPW  = 3'd5
    } state_t;

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    localparam logic [7:0]  GAP_LAST  = 8'(GAP - 1);

    state_t      state_q;
    logic [15:0] len_q;
    logic [15:0] csum_q;
    logic [15:0] words_left_q;
    logic [3:0]  hdr_idx_q;
    logic [7:0]  gap_cnt_q;

    logic        pl_rd_q;
    logic        pl_done_q;
    logic        en_udp_q;
    logic        tx_wren_q;
    logic        tx_sop_q;
    logic        tx_eop_q;
    logic [1:0]  tx_mod_q;
    logic [31:0] tx_data_q;

    logic [15:0] ip_id;
`ifdef UDP_IPID_INC_EN
    logic [15:0] ip_id_q;
    assign ip_id = ip_id_q;
`else
    assign ip_id = 16'h0000;
`endif

    logic [15:0] tot_len;
    logic [15:0] udp_len;
    logic        len_bad;
    logic [15:0] pay_words;
    logic [19:0] csum_acc;
    logic [16:0] csum_f1;
    logic [15:0] csum_calc;
    logic [31:0] hdr_word;
    logic [31:0] last_mask;
    logic [1:0]  last_mod;

    assign tot_len   = len_q + 16'd28;
    assign udp_len   = len_q + 16'd8;
    assign len_bad   = (len_q == 16'd0) || (len_q > MAX_LEN_W);
    assign pay_words = 16'((17'(len_q) + 17'd3) >> 2);
    assign last_mod  = 2'd0 - len_q[1:0];

    // IPv4 header checksum: ones-complement sum of the ten header halfwords
    // (checksum field taken as zero), folded twice, then inverted.
    always_comb begin
        csum_acc = 20'h04500 + 20'(tot_len) + 20'(ip_id) + 20'h04000 + 20'h04011
                 + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
                 + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
        csum_f1   = 17'(csum_acc[15:0]) + 17'(csum_acc[19:16]);
        csum_calc = ~(csum_f1[15:0] + 16'(csum_f1[16]));
    end

    // Header word selected by the running header index (W0..W10).
    always_comb begin
        hdr_word = 32'h0;
        case (hdr_idx_q)
            4'd0:    hdr_word = {16'h0000, DST_MAC[47:32]};
            4'd1:    hdr_word = DST_MAC[31:0];
            4'd2:    hdr_word = SRC_MAC[47:16];
            4'd3:    hdr_word = {SRC_MAC[15:0], 16'h0800};
            4'd4:    hdr_word = {16'h4500, tot_len};
            4'd5:    hdr_word = {ip_id, 16'h4000};
            4'd6:    hdr_word = {8'd64, 8'd17, csum_q};
            4'd7:    hdr_word = SRC_IP;
            4'd8:    hdr_word = DST_IP;
            4'd9:    hdr_word = {SRC_PORT, DST_PORT};
            4'd10:   hdr_word = {udp_len, 16'h0000};
            default: hdr_word = 32'h0;
        endcase
    end

    // Bytes of the final payload word that carry data; the rest are zeroed.
    always_comb begin
        last_mask = 32'hFFFF_FFFF;
        case (len_q[1:0])
            2'd1:    last_mask = 32'hFF00_0000;
            2'd2:    last_mask = 32'hFFFF_0000;
            2'd3:    last_mask = 32'hFFFF_FF00;
            default: last_mask = 32'hFFFF_FFFF;
        endcase
    end

    // Frame sequencer; every port output is a register set one cycle after
    // the state decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= 16'h0;
            csum_q       <= 16'h0;
            words_left_q <= 16'h0;
            hdr_idx_q    <= 4'h0;
            gap_cnt_q    <= 8'h0;
            pl_rd_q      <= 1'b0;
            pl_done_q    <= 1'b0;
            en_udp_q     <= 1'b0;
            tx_wren_q    <= 1'b0;
            tx_sop_q     <= 1'b0;
            tx_eop_q     <= 1'b0;
            tx_mod_q     <= 2'd0;
            tx_data_q    <= 32'h0;
`ifdef UDP_IPID_INC_EN
            ip_id_q      <= 16'h0;
`endif
        end else begin
            pl_done_q <= 1'b0;
            tx_sop_q  <= 1'b0;
            tx_eop_q  <= 1'b0;
            tx_mod_q  <= 2'd0;
            case (state_q)
                S_IDLE: begin
                    pl_rd_q   <= 1'b0;
                    en_udp_q  <= 1'b0;
                    tx_wren_q <= 1'b0;
                    tx_data_q <= 32'h0;
                    if (bus.pl_valid) begin
                        len_q   <= bus.pl_len;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (len_bad) begin
                        pl_done_q <= 1'b1;
                        gap_cnt_q <= 8'h0;
                        state_q   <= S_GAPW;
                    end else begin
                        csum_q       <= csum_calc;
                        words_left_q <= pay_words;
                        hdr_idx_q    <= 4'd0;
                        en_udp_q     <= 1'b1;
                        state_q      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.tx_rdy) begin
                        en_udp_q  <= 1'b0;
                        tx_wren_q <= 1'b1;
                        tx_sop_q  <= 1'b1;
                        tx_data_q <= hdr_word;
                        hdr_idx_q <= hdr_idx_q + 4'd1;
                        state_q   <= S_HDR;
                    end
                end
                S_HDR: begin
                    tx_wren_q <= 1'b1;
                    tx_data_q <= hdr_word;
                    hdr_idx_q <= hdr_idx_q + 4'd1;
                    if (hdr_idx_q == 4'd10) begin
                        // Raise pl_rd now so it is high during each PAY cycle.
                        pl_rd_q <= 1'b1;
                        state_q <= S_PAY;
                    end
                end
                S_PAY: begin
                    tx_wren_q    <= 1'b1;
                    words_left_q <= words_left_q - 16'd1;
                    if (words_left_q == 16'd1) begin
                        tx_data_q <= bus.pl_data & last_mask;
                        tx_eop_q  <= 1'b1;
                        tx_mod_q  <= last_mod;
                        pl_rd_q   <= 1'b0;
                        pl_done_q <= 1'b1;
                        gap_cnt_q <= 8'h0;
                        state_q   <= S_GAPW;
`ifdef UDP_IPID_INC_EN
                        ip_id_q   <= ip_id_q + 16'd1;
`endif
                    end else begin
                        tx_data_q <= bus.pl_data;
                    end
                end
                S_GAPW: begin
                    pl_rd_q   <= 1'b0;
                    en_udp_q  <= 1'b0;
                    tx_wren_q <= 1'b0;
                    tx_data_q <= 32'h0;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.pl_rd   = pl_rd_q;
    assign bus.pl_done = pl_done_q;
    assign bus.en_udp  = en_udp_q;
    assign bus.tx_wren = tx_wren_q;
    assign bus.tx_sop  = tx_sop_q;
    assign bus.tx_eop  = tx_eop_q;
    assign bus.tx_mod  = tx_mod_q;
    assign bus.tx_data = tx_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Bench for udp_tx_framer: builds each expected frame byte-by-byte from the
// protocol layout, queues its words, and a negedge monitor compares every
// word the framer emits.
module tb_udp_tx_framer;
    localparam logic [47:0] SRC_MAC  = 48'h0200_0000_0001;
    localparam logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] SRC_IP   = 32'hC0A8_0001;
    localparam logic [31:0] DST_IP   = 32'hC0A8_0002;
    localparam logic [15:0] SRC_PORT = 16'd5000;
    localparam logic [15:0] DST_PORT = 16'd5001;
    localparam int          MAX_LEN  = 1472;
    localparam int          GAP      = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    udp_tx_framer_if bus();
    logic [2:0] dbg_state;

    udp_tx_framer dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];
    logic [15:0] exp_id = 16'h0;

    // ---------------- payload buffer model ----------------
    logic [31:0] pay_mem [0:511];
    logic [7:0]  pay_bytes [0:2047];
    logic [31:0] rd_cnt = 32'h0;
    logic [31:0] rd_base = 32'h0;
    logic [31:0] rd_idx;
    assign rd_idx = rd_cnt - rd_base;
    assign bus.pl_data = (rd_idx < 32'd512) ? pay_mem[rd_idx[8:0]] : 32'hDEAD_BEEF;
    always @(posedge clk) if (!rst && bus.pl_rd) rd_cnt <= rd_cnt + 32'd1;

    // ---------------- reference model ----------------
    function automatic void push_frame(input int len, input logic [15:0] id);
        logic [7:0]  fb[$];
        logic [15:0] tot;
        logic [15:0] ulen;
        logic [31:0] s;
        logic [15:0] ck;
        int          nw;
        logic [31:0] w;
        logic [1:0]  m;
        tot  = 16'(len + 28);
        ulen = 16'(len + 8);
        fb.push_back(8'h00); fb.push_back(8'h00);
        for (int i = 5; i >= 0; i--) fb.push_back(DST_MAC[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fb.push_back(SRC_MAC[8*i +: 8]);
        fb.push_back(8'h08); fb.push_back(8'h00);
        fb.push_back(8'h45); fb.push_back(8'h00);
        fb.push_back(tot[15:8]); fb.push_back(tot[7:0]);
        fb.push_back(id[15:8]);  fb.push_back(id[7:0]);
        fb.push_back(8'h40); fb.push_back(8'h00);
        fb.push_back(8'd64); fb.push_back(8'd17);
        fb.push_back(8'h00); fb.push_back(8'h00);
        for (int i = 3; i >= 0; i--) fb.push_back(SRC_IP[8*i +: 8]);
        for (int i = 3; i >= 0; i--) fb.push_back(DST_IP[8*i +: 8]);
        s = 32'h0;
        for (int i = 0; i < 10; i++) s = s + {16'h0, fb[16 + 2*i], fb[17 + 2*i]};
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        ck = ~s[15:0];
        fb[26] = ck[15:8];
        fb[27] = ck[7:0];
        fb.push_back(SRC_PORT[15:8]); fb.push_back(SRC_PORT[7:0]);
        fb.push_back(DST_PORT[15:8]); fb.push_back(DST_PORT[7:0]);
        fb.push_back(ulen[15:8]); fb.push_back(ulen[7:0]);
        fb.push_back(8'h00); fb.push_back(8'h00);
        for (int i = 0; i < len; i++) fb.push_back(pay_bytes[i]);
        while (fb.size() % 4 != 0) fb.push_back(8'h00);
        nw = fb.size() / 4;
        for (int i = 0; i < nw; i++) begin
            w = {fb[4*i], fb[4*i+1], fb[4*i+2], fb[4*i+3]};
            m = (i == nw - 1) ? 2'((4 - (len % 4)) % 4) : 2'd0;
            exp_q.push_back({(i == 0), (i == nw - 1), m, w});
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int   cycle = 0;
    int   done_cnt = 0;
    int   last_eop_cyc = -100;
    bit   in_frame = 1'b0;
    bit   en_prev = 1'b0;
    logic [35:0] got;
    logic [35:0] exp;

    // Compares every emitted word against the expected queue and watches
    // frame contiguity, idle-bus cleanliness and the inter-frame gap.
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            in_frame = 1'b0;
            en_prev  = 1'b0;
        end else begin
            if (bus.pl_done) done_cnt++;
            if (bus.en_udp && !en_prev) begin
                checks++;
                if (cycle - last_eop_cyc <= GAP) begin
                    errors++;
                    $display("FAIL gap: request %0d cycles after eop, need more than %0d",
                             cycle - last_eop_cyc, GAP);
                end
            end
            en_prev = bus.en_udp;
            got = {bus.tx_sop, bus.tx_eop, bus.tx_mod, bus.tx_data};
            if (in_frame) begin
                checks++;
                if (!bus.tx_wren) begin
                    errors++;
                    $display("FAIL contiguity: wren dropped mid-frame at cycle %0d", cycle);
                    in_frame = 1'b0;
                end
            end
            if (bus.tx_wren) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h with nothing expected", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL word: got sop/eop/mod/data %h, expected %h", got, exp);
                    end
                end
                in_frame = !bus.tx_eop;
                if (bus.tx_eop) last_eop_cyc = cycle;
            end else begin
                checks++;
                if (got !== 36'h0) begin
                    errors++;
                    $display("FAIL idle_bus: got %h, expected 0", got);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic send_frame(input int len, input int stall);
        int n;
        int bad;
        int done0;
        bit ok_len;
        ok_len = (len >= 1) && (len <= MAX_LEN);
        done0  = done_cnt;
        for (int i = 0; i < 512; i++) pay_mem[i] = $urandom;
        for (int i = 0; i < len && i < 2048; i++) pay_bytes[i] = pay_mem[i/4][31 - 8*(i%4) -: 8];
        rd_base = rd_cnt;
        if (ok_len) push_frame(len, exp_id);
        bus.pl_len   = 16'(len);
        bus.pl_valid = 1'b1;
        if (!ok_len) begin
            n = 0; bad = 0;
            while (done_cnt == done0 && n < 20) begin
                tick(); n++;
                if (bus.en_udp || bus.tx_wren || bus.pl_rd) bad++;
            end
            check("reject_done", n < 20, n, 2);
            check("reject_quiet", bad == 0, bad, 0);
            check("reject_no_rd", rd_cnt == rd_base, int'(rd_cnt - rd_base), 0);
            tick();
            check("reject_done_once", done_cnt - done0 == 1, done_cnt - done0, 1);
            bus.pl_valid = 1'b0;
        end else begin
            n = 0;
            while (!bus.en_udp && n < 50) begin tick(); n++; end
            check("en_udp_rise", n < 50, n, 2);
            bad = 0;
            for (int s = 0; s < stall; s++) begin
                if (!bus.en_udp || bus.tx_wren) bad++;
                tick();
            end
            check("req_hold", bad == 0, bad, 0);
            bus.tx_rdy = 1'b1;
            tick();
            check("sop_after_rdy", bus.tx_sop && bus.tx_wren && !bus.en_udp,
                  int'({bus.tx_sop, bus.tx_wren, bus.en_udp}), 6);
            n = 0;
            while (done_cnt == done0 && n < 2000) begin tick(); n++; end
            check("pl_done_seen", n < 2000, n, (len + 3) / 4 + 10);
            check("pl_rd_count", int'(rd_cnt - rd_base) == (len + 3) / 4,
                  int'(rd_cnt - rd_base), (len + 3) / 4);
            tick();
            check("pl_done_once", done_cnt - done0 == 1, done_cnt - done0, 1);
            bus.tx_rdy   = 1'b0;
            bus.pl_valid = 1'b0;
`ifdef UDP_IPID_INC_EN
            exp_id = exp_id + 16'd1;
`endif
        end
    endtask

    task automatic reset_mid_pay();
        int n;
        for (int i = 0; i < 512; i++) pay_mem[i] = $urandom;
        for (int i = 0; i < 100; i++) pay_bytes[i] = pay_mem[i/4][31 - 8*(i%4) -: 8];
        rd_base = rd_cnt;
        push_frame(100, exp_id);
        bus.pl_len   = 16'd100;
        bus.pl_valid = 1'b1;
        n = 0;
        while (!bus.en_udp && n < 50) begin tick(); n++; end
        check("rst_test_req", n < 50, n, 2);
        bus.tx_rdy = 1'b1;
        repeat (16) tick();
        check("rst_test_in_pay", bus.tx_wren && bus.pl_rd, int'({bus.tx_wren, bus.pl_rd}), 3);
        rst = 1'b1;
        #1;
        check("rst_mid_pay_outputs",
              {bus.pl_rd, bus.pl_done, bus.en_udp, bus.tx_wren, bus.tx_sop,
               bus.tx_eop, bus.tx_mod, bus.tx_data, dbg_state} == 44'h0,
              int'({bus.pl_rd, bus.en_udp, bus.tx_wren}), 0);
        exp_q.delete();
        bus.pl_valid = 1'b0;
        bus.tx_rdy   = 1'b0;
        exp_id       = 16'h0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int len;
        rst          = 1'b1;
        bus.pl_valid = 1'b0;
        bus.pl_len   = 16'h0;
        bus.tx_rdy   = 1'b0;
        repeat (3) tick();
        check("reset_state",
              {bus.pl_rd, bus.pl_done, bus.en_udp, bus.tx_wren, bus.tx_sop,
               bus.tx_eop, bus.tx_mod, bus.tx_data, dbg_state} == 44'h0,
              int'({bus.pl_rd, bus.pl_done, bus.en_udp, bus.tx_wren}), 0);
        rst = 1'b0;
        tick();

        send_frame(18, 0);
        send_frame(1, 0);
        send_frame(1472, 1);
        send_frame(5, 20);
        send_frame(0, 0);
        send_frame(1473, 0);
        send_frame(7, 2);
        send_frame(40, 0);
        send_frame(33, 3);
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 9) == 0) len = $urandom_range(1473, 4000);
            else                           len = $urandom_range(1, 400);
            send_frame(len, $urandom_range(0, 6));
        end
        reset_mid_pay();
        send_frame(20, 1);
        send_frame(4, 0);

        repeat (10) tick();
        check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, %0d errors so far", errors);
        $fatal(1, "timeout");
    end
endmodule
